// File: rtl/vram_pixel_sink.sv
// Pixel write sink: range-checks and offsets rasterizer pixels, queues them
// in a small FIFO and drains them to SRAM through a req/ack write port.
module vram_pixel_sink #(
  parameter int          DEPTH   = 8,
  parameter logic [17:0] FB_SIZE = 18'd76800
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       pix_we_i,
  input  logic                       pix_offset_i,
  input  logic [17:0]                pix_addr_i,
  input  logic [15:0]                pix_color_i,
  output logic                       pix_full_o,
  output logic                       sram_req_o,
  output logic [17:0]                sram_addr_o,
  output logic [15:0]                sram_data_o,
  input  logic                       sram_ack_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovf_o,
  output logic                       range_err_o,
  input  logic                       clr_err_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [33:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [17:0]   r_addr;
  logic [15:0]   r_data;
  logic          r_ovf;
  logic          r_rerr;

  logic          w_full;
  logic          w_pop;
  logic          w_in_range;
  logic          w_push;
  logic          w_range_set;
  logic          w_ovf_set;
  logic [17:0]   w_phys;
  logic [33:0]   w_in_word;
  logic [AW-1:0] w_rptr_inc;
  logic [AW:0]   w_level_nxt;
  logic [33:0]   w_next_word;
  logic          w_load;
  logic [33:0]   w_load_word;

  assign w_full      = (r_level == FULL_LVL);
  assign w_pop       = (r_state == S_REQ) && sram_ack_i;
  assign w_in_range  = (pix_addr_i < FB_SIZE);
  assign w_push      = pix_we_i && w_in_range && (!w_full || w_pop);
  assign w_range_set = pix_we_i && !w_in_range;
  assign w_ovf_set   = pix_we_i && w_in_range && w_full && !w_pop;
  assign w_phys      = pix_addr_i + (pix_offset_i ? FB_SIZE : 18'd0);
  assign w_in_word   = {w_phys, pix_color_i};
  assign w_rptr_inc  = r_rptr + 1'b1;

  // With one entry left, the follow-on head is the pixel arriving this edge.
  assign w_next_word = (r_level > ONE_LVL) ? r_mem[w_rptr_inc] : w_in_word;

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + ONE_LVL;
      2'b01:   w_level_nxt = r_level - ONE_LVL;
      default: w_level_nxt = r_level;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_word = r_mem[r_rptr];
    unique case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_state_nxt = S_REQ;
          w_load      = 1'b1;
          w_load_word = r_mem[r_rptr];
        end
      end
      S_REQ: begin
        if (w_pop) begin
          if (w_level_nxt != '0) begin
            w_load      = 1'b1;
            w_load_word = w_next_word;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push && !wb_rst_i) begin
      r_mem[r_wptr] <= w_in_word;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_inc;
      end
      r_level <= w_level_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_load) begin
      r_addr <= w_load_word[33:16];
      r_data <= w_load_word[15:0];
    end
  end

  // A flag-setting event on the same edge as clear keeps the flag set.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ovf  <= 1'b0;
      r_rerr <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clr_err_i) begin
        r_ovf <= 1'b0;
      end
      if (w_range_set) begin
        r_rerr <= 1'b1;
      end else if (clr_err_i) begin
        r_rerr <= 1'b0;
      end
    end
  end

  assign pix_full_o  = w_full;
  assign sram_req_o  = (r_state == S_REQ);
  assign sram_addr_o = r_addr;
  assign sram_data_o = r_data;
  assign level_o     = r_level;
  assign ovf_o       = r_ovf;
  assign range_err_o = r_rerr;

endmodule

// File: tb/tb_vram_pixel_sink.sv
// Bench for vram_pixel_sink: vector table plus scoreboard of SRAM writes.
module tb_vram_pixel_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic        off = 1'b0;
  logic [17:0] addr = '0;
  logic [15:0] color = '0;
  logic        ack = 1'b0;
  logic        clr = 1'b0;
  logic        full;
  logic        req;
  logic [17:0] s_addr;
  logic [15:0] s_data;
  logic [3:0]  level;
  logic        ovf;
  logic        rerr;

  vram_pixel_sink dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .pix_we_i    (we),
    .pix_offset_i(off),
    .pix_addr_i  (addr),
    .pix_color_i (color),
    .pix_full_o  (full),
    .sram_req_o  (req),
    .sram_addr_o (s_addr),
    .sram_data_o (s_data),
    .sram_ack_i  (ack),
    .level_o     (level),
    .ovf_o       (ovf),
    .range_err_o (rerr),
    .clr_err_i   (clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] addr;
    logic        off;
    logic [15:0] color;
    logic [17:0] exp_addr;
    logic        exp_rerr;
  } vec_t;

  vec_t        vecs [6];
  logic [33:0] sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_cnt = 0;
  int          wr_first = -1;
  int          wr_last = -1;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A write completes on the posedge following a negedge with req and ack high.
  always @(negedge clk) begin
    if (!rst && req && ack) begin
      logic [33:0] e;
      wr_cnt = wr_cnt + 1;
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
      n_checks = n_checks + 1;
      if (sb_q.size() == 0) begin
        n_errors = n_errors + 1;
        $display("FAIL unexpected_write act=%05h/%04h exp=none",
                 s_addr, s_data);
      end else begin
        e = sb_q.pop_front();
        if ({s_addr, s_data} !== e) begin
          n_errors = n_errors + 1;
          $display("FAIL sram_write act=%05h/%04h exp=%05h/%04h",
                   s_addr, s_data, e[33:16], e[15:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [35:0] act,
                     input logic [35:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((level != 0 || req) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 36'(n >= budget), 36'd0);
  endtask

  task automatic strobe(input logic [17:0] a, input logic o,
                        input logic [15:0] c);
    we = 1'b1;
    addr = a;
    off = o;
    color = c;
  endtask

  initial begin
    int wr0;
    int maxlvl;
    logic ovf_seen;

    vecs[0] = '{18'h00010, 1'b0, 16'hF800, 18'h00010, 1'b0};
    vecs[1] = '{18'h00000, 1'b1, 16'h07E0, 18'h12C00, 1'b0};
    vecs[2] = '{18'h12BFF, 1'b1, 16'h001F, 18'h257FF, 1'b0};
    vecs[3] = '{18'h12C00, 1'b0, 16'hFFFF, 18'h00000, 1'b1};
    vecs[4] = '{18'h12BFF, 1'b0, 16'h1234, 18'h12BFF, 1'b0};
    vecs[5] = '{18'h3FFFF, 1'b1, 16'hBEEF, 18'h00000, 1'b1};

    repeat (2) tick();
    chk("rst_level", 36'(level), 36'd0);
    chk("rst_req", 36'(req), 36'd0);
    chk("rst_full", 36'(full), 36'd0);
    chk("rst_flags", 36'({ovf, rerr}), 36'd0);
    chk("rst_sram", 36'({s_addr, s_data}), 36'd0);
    rst = 1'b0;
    tick();

    ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr0 = wr_cnt;
      strobe(vecs[i].addr, vecs[i].off, vecs[i].color);
      if (!vecs[i].exp_rerr) sb_q.push_back({vecs[i].exp_addr, vecs[i].color});
      tick();
      we = 1'b0;
      chk("vec_range_err", 36'(rerr), 36'(vecs[i].exp_rerr));
      if (i == 0) begin
        chk("lat_req_n", 36'(req), 36'd0);
        tick();
        chk("lat_req_n1", 36'(req), 36'd1);
      end
      drain(10);
      chk("vec_writes", 36'(wr_cnt - wr0), 36'(!vecs[i].exp_rerr));
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("vec_clr", 36'(rerr), 36'd0);
    end

    ack = 1'b0;
    wr0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      strobe(18'(i), 1'b0, 16'hA000 + 16'(i));
      if (i < 8) sb_q.push_back({18'(i), 16'hA000 + 16'(i)});
      tick();
    end
    we = 1'b0;
    chk("bp_level", 36'(level), 36'd8);
    chk("bp_full", 36'(full), 36'd1);
    chk("bp_ovf", 36'(ovf), 36'd1);
    chk("bp_hold", 36'({req, s_addr, s_data}), {1'b1, 18'd0, 16'hA000});
    chk("bp_no_write", 36'(wr_cnt - wr0), 36'd0);
    ack = 1'b1;
    drain(30);
    chk("bp_writes", 36'(wr_cnt - wr0), 36'd8);
    chk("bp_level_end", 36'(level), 36'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("bp_clr", 36'(ovf), 36'd0);

    ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      strobe(18'h100 + 18'(i), 1'b1, 16'h5000 + 16'(i));
      sb_q.push_back({18'h100 + 18'(i) + 18'h12C00, 16'h5000 + 16'(i)});
      tick();
    end
    chk("fp_full", 36'({full, ovf}), 36'b10);
    ack = 1'b1;
    strobe(18'h200, 1'b0, 16'h6666);
    sb_q.push_back({18'h200, 16'h6666});
    tick();
    we = 1'b0;
    chk("fp_level", 36'(level), 36'd8);
    chk("fp_ovf", 36'(ovf), 36'd0);
    drain(30);
    chk("fp_empty", 36'(sb_q.size()), 36'd0);

    wr0 = wr_cnt;
    wr_first = -1;
    maxlvl = 0;
    ovf_seen = 1'b0;
    for (int i = 0; i < 320; i++) begin
      strobe(18'(i), 1'b0, 16'(i * 7 + 1));
      sb_q.push_back({18'(i), 16'(i * 7 + 1)});
      tick();
      if (int'(level) > maxlvl) maxlvl = int'(level);
      ovf_seen = ovf_seen | ovf;
    end
    we = 1'b0;
    drain(20);
    chk("st_writes", 36'(wr_cnt - wr0), 36'd320);
    chk("st_consec", 36'(wr_last - wr_first + 1), 36'd320);
    chk("st_level_le2", 36'(maxlvl <= 2), 36'd1);
    chk("st_ovf", 36'(ovf_seen), 36'd0);

    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(18'h300 + 18'(i), 1'b0, 16'h7000 + 16'(i));
      tick();
    end
    chk("rm_queued", 36'({req, level}), {31'd0, 1'b1, 4'd3});
    rst = 1'b1;
    strobe(18'h5, 1'b0, 16'h1111);
    tick();
    rst = 1'b0;
    we = 1'b0;
    chk("rm_req", 36'(req), 36'd0);
    chk("rm_level", 36'(level), 36'd0);
    chk("rm_sram", 36'({s_addr, s_data}), 36'd0);
    sb_q.delete();
    wr0 = wr_cnt;
    ack = 1'b1;
    repeat (10) tick();
    chk("rm_no_write", 36'(wr_cnt - wr0), 36'd0);
    chk("rm_idle", 36'({req, level}), 36'd0);
    chk("sb_empty", 36'(sb_q.size()), 36'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
